// File: rtl/down_cnt_timer.sv
// Loadable down-counter/timer with terminal-count pulse and optional auto-reload.
// Optional prescaler on the enable path is built when DOWN_CNT_PRESCALE_EN is defined.
module down_cnt_timer #(
  parameter int M    = 8,
  parameter int PS_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         load,
  input  logic [M-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
`ifdef DOWN_CNT_PRESCALE_EN
  input  logic [PS_W-1:0] ps_div,
`endif
  output logic [M-1:0] q,
  output logic         tc,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [M-1:0] CNT_ZERO = '0;
  localparam logic [M-1:0] CNT_ONE  = M'(1);

  state_t       state, state_nxt;
  logic [M-1:0] reload, reload_nxt;
  logic [M-1:0] q_nxt;
  logic         tc_nxt;
  logic         busy_nxt;
  logic         dec;

`ifdef DOWN_CNT_PRESCALE_EN
  localparam logic [PS_W-1:0] PS_ZERO = '0;
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps, ps_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      reload <= '0;
      q      <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
`ifdef DOWN_CNT_PRESCALE_EN
      ps     <= '0;
`endif
    end else begin
      state  <= state_nxt;
      reload <= reload_nxt;
      q      <= q_nxt;
      tc     <= tc_nxt;
      busy   <= busy_nxt;
`ifdef DOWN_CNT_PRESCALE_EN
      ps     <= ps_nxt;
`endif
    end
  end

  // Priority: load, then stop (which also masks start), then start, then count.
  always_comb begin
    state_nxt  = state;
    reload_nxt = reload;
    q_nxt      = q;
    tc_nxt     = 1'b0;
    busy_nxt   = busy;
    dec        = 1'b0;
`ifdef DOWN_CNT_PRESCALE_EN
    ps_nxt     = ps;
`endif

    if (load) begin
      q_nxt      = load_val;
      reload_nxt = load_val;
      state_nxt  = IDLE;
      busy_nxt   = 1'b0;
`ifdef DOWN_CNT_PRESCALE_EN
      ps_nxt     = PS_ZERO;
`endif
    end else if (stop) begin
      if (state == RUN) begin
        state_nxt = PAUSE;
        busy_nxt  = 1'b0;
      end
    end else if (start && (state == IDLE || state == PAUSE)) begin
      if (q != CNT_ZERO) begin
        state_nxt = RUN;
        busy_nxt  = 1'b1;
      end
    end else if (state == RUN && ce) begin
`ifdef DOWN_CNT_PRESCALE_EN
      if (ps == ps_div) begin
        ps_nxt = PS_ZERO;
        dec    = 1'b1;
      end else begin
        ps_nxt = ps + PS_ONE;
      end
`else
      dec = 1'b1;
`endif
    end

    if (dec) begin
      if (q == CNT_ONE) begin
        tc_nxt = 1'b1;
        if (auto_reload && reload != CNT_ZERO) begin
          q_nxt = reload;
        end else begin
          q_nxt     = CNT_ZERO;
          state_nxt = DONE;
          busy_nxt  = 1'b0;
`ifdef DOWN_CNT_PRESCALE_EN
          ps_nxt    = PS_ZERO;
`endif
        end
      end else if (q != CNT_ZERO) begin
        q_nxt = q - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_down_cnt_timer.sv
// Self-checking bench for down_cnt_timer: directed vector table, hand-written
// corner sequences, and randomized stimulus against a behavioural model.
module tb_down_cnt_timer;

  localparam int M    = 8;
  localparam int PS_W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce, load, start, stop, auto_reload;
  logic [M-1:0] load_val;
  logic [PS_W-1:0] ps_div;
  logic [M-1:0] q;
  logic         tc, busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  down_cnt_timer #(.M(M), .PS_W(PS_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .stop       (stop),
    .auto_reload(auto_reload),
`ifdef DOWN_CNT_PRESCALE_EN
    .ps_div     (ps_div),
`endif
    .q          (q),
    .tc         (tc),
    .busy       (busy)
  );

  typedef struct {
    logic         ld;
    logic [M-1:0] lv;
    logic         st;
    logic         sp;
    logic         c;
    logic         ar;
    logic [M-1:0] eq;
    logic         etc;
    logic         eb;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: count value, reload value and a few flags.
  logic [M-1:0]    m_q, m_rl;
  logic [PS_W-1:0] m_ps;
  bit              m_running, m_done, m_tc;

  task automatic add(input logic ld, input logic [M-1:0] lv, input logic st, input logic sp,
                     input logic c, input logic ar, input logic [M-1:0] eq, input logic etc,
                     input logic eb);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.c = c; v.ar = ar;
    v.eq = eq; v.etc = etc; v.eb = eb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [M-1:0] eq, input logic etc, input logic eb);
    vectors++;
    if (q !== eq || tc !== etc || busy !== eb) begin
      miscompares++;
      $display("FAIL %s: got q=%h tc=%b busy=%b, expected q=%h tc=%b busy=%b",
               name, q, tc, busy, eq, etc, eb);
    end
  endtask

  task automatic step(input logic ld, input logic [M-1:0] lv, input logic st, input logic sp,
                      input logic c, input logic ar);
    load = ld; load_val = lv; start = st; stop = sp; ce = c; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q = '0; m_rl = '0; m_ps = '0; m_running = 0; m_done = 0; m_tc = 0;
  endtask

  task automatic model_edge(input logic ld, input logic [M-1:0] lv, input logic st,
                            input logic sp, input logic c, input logic ar,
                            input logic [PS_W-1:0] div);
    bit tick;
    m_tc = 0;
    tick = 0;
    if (ld) begin
      m_q = lv; m_rl = lv; m_running = 0; m_done = 0; m_ps = '0;
    end else if (sp) begin
      m_running = 0;
    end else if (st && !m_running && !m_done) begin
      if (m_q != 0) m_running = 1;
    end else if (m_running && c) begin
`ifdef DOWN_CNT_PRESCALE_EN
      if (m_ps == div) begin
        m_ps = '0;
        tick = 1;
      end else begin
        m_ps = m_ps + 1'b1;
      end
`else
      tick = 1;
`endif
    end
    if (tick) begin
      if (m_q == 1) begin
        m_tc = 1;
        if (ar && m_rl != 0) begin
          m_q = m_rl;
        end else begin
          m_q = 0; m_running = 0; m_done = 1; m_ps = '0;
        end
      end else begin
        m_q = m_q - 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 0; load = 0; load_val = '0; start = 0; stop = 0;
    auto_reload = 0; ps_div = '0;
    #3;
    chk("reset_state", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot run from 5
    add(1, 8'd5, 0, 0, 0, 0, 8'd5, 0, 0);
    add(0, 8'd0, 1, 0, 0, 0, 8'd5, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd4, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd3, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd2, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd1, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd0, 1, 0);
    add(0, 8'd0, 1, 0, 1, 0, 8'd0, 0, 0);
    add(0, 8'd0, 0, 1, 1, 0, 8'd0, 0, 0);
    // Auto-reload period 3, 12 enabled cycles, 4 tc pulses
    add(1, 8'd3, 0, 0, 0, 1, 8'd3, 0, 0);
    add(0, 8'd0, 1, 0, 0, 1, 8'd3, 0, 1);
    for (int i = 0; i < 4; i++) begin
      add(0, 8'd0, 0, 0, 1, 1, 8'd2, 0, 1);
      add(0, 8'd0, 0, 0, 1, 1, 8'd1, 0, 1);
      add(0, 8'd0, 0, 0, 1, 1, 8'd3, 1, 1);
    end
    // Pause with stop+start together, then resume
    add(1, 8'd10, 0, 0, 0, 0, 8'd10, 0, 0);
    add(0, 8'd0, 1, 0, 0, 0, 8'd10, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd9, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd8, 0, 1);
    add(0, 8'd0, 1, 1, 1, 0, 8'd8, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 8'd0, 0, 0, 1, 0, 8'd8, 0, 0);
    add(0, 8'd0, 1, 0, 0, 0, 8'd8, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd7, 0, 1);
    add(0, 8'd0, 0, 0, 0, 0, 8'd7, 0, 1);
    // ce toggling from 4: tc on the 8th clock after start
    add(1, 8'd4, 0, 0, 0, 0, 8'd4, 0, 0);
    add(0, 8'd0, 1, 0, 0, 0, 8'd4, 0, 1);
    add(0, 8'd0, 0, 0, 0, 0, 8'd4, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd3, 0, 1);
    add(0, 8'd0, 0, 0, 0, 0, 8'd3, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd2, 0, 1);
    add(0, 8'd0, 0, 0, 0, 0, 8'd2, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd1, 0, 1);
    add(0, 8'd0, 0, 0, 0, 0, 8'd1, 0, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd0, 1, 0);
    add(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0);
    // Reload of 1 with ce high: tc stays high
    add(1, 8'd1, 0, 0, 0, 1, 8'd1, 0, 0);
    add(0, 8'd0, 1, 0, 0, 1, 8'd1, 0, 1);
    add(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 1);
    add(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 1);
    add(0, 8'd0, 0, 0, 1, 0, 8'd0, 1, 0);
    add(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].c, tbl[i].ar);
      chk($sformatf("table[%0d]", i), tbl[i].eq, tbl[i].etc, tbl[i].eb);
    end

    // Asynchronous reset mid-run
    step(1, 8'h23, 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1, 0);
    chk("pre_async_reset", 8'h20, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Reset while tc is high
    step(1, 8'h01, 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    chk("tc_before_reset", 8'h00, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("tc_async_reset", 8'h00, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Start with q=0 after reset is ignored
    step(0, 8'h00, 1, 0, 1, 0);
    chk("start_zero", 8'h00, 1'b0, 1'b0);
    step(0, 8'h00, 1, 0, 1, 1);
    chk("start_zero_again", 8'h00, 1'b0, 1'b0);

`ifdef DOWN_CNT_PRESCALE_EN
    ps_div = 4'd2;
    step(1, 8'd2, 0, 0, 0, 0);
    step(0, 8'd0, 1, 0, 0, 0);
    chk("ps_start", 8'd2, 1'b0, 1'b1);
    step(0, 8'd0, 0, 0, 1, 0);
    step(0, 8'd0, 0, 0, 1, 0);
    chk("ps_hold", 8'd2, 1'b0, 1'b1);
    step(0, 8'd0, 0, 0, 1, 0);
    chk("ps_first_dec", 8'd1, 1'b0, 1'b1);
    step(0, 8'd0, 0, 0, 1, 0);
    step(0, 8'd0, 0, 0, 1, 0);
    step(0, 8'd0, 0, 0, 1, 0);
    chk("ps_tc", 8'd0, 1'b1, 1'b0);
    step(1, 8'd2, 0, 0, 0, 0);
    step(0, 8'd0, 1, 0, 0, 0);
    step(0, 8'd0, 0, 0, 1, 0);
    step(0, 8'd0, 0, 0, 1, 0);
    step(1, 8'h80, 0, 0, 1, 0);
    chk("ps_load_in_run", 8'h80, 1'b0, 1'b0);
    step(0, 8'd0, 0, 0, 1, 0);
    chk("ps_idle_after_load", 8'h80, 1'b0, 1'b0);
    step(0, 8'd0, 1, 0, 0, 0);
    step(0, 8'd0, 0, 0, 1, 0);
    step(0, 8'd0, 0, 0, 1, 0);
    chk("ps_cleared_by_load", 8'h80, 1'b0, 1'b1);
    step(0, 8'd0, 0, 0, 1, 0);
    chk("ps_dec_after_load", 8'h7f, 1'b0, 1'b1);
`endif

    // Randomized run against the model
    do_reset();
    chk("rand_reset", m_q, m_tc, m_running);
    begin
      logic r_ld, r_st, r_sp, r_c, r_ar;
      logic [M-1:0] r_lv;
      r_ar = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        r_ld = ($urandom_range(15) == 0);
        r_lv = ($urandom_range(3) == 0) ? M'($urandom_range(255)) : M'($urandom_range(6));
        r_st = ($urandom_range(3) == 0);
        r_sp = ($urandom_range(9) == 0);
        r_c  = ($urandom_range(3) != 0);
        if ($urandom_range(19) == 0) r_ar = ~r_ar;
`ifdef DOWN_CNT_PRESCALE_EN
        if (r_ld) ps_div = PS_W'($urandom_range(3));
`endif
        step(r_ld, r_lv, r_st, r_sp, r_c, r_ar);
        model_edge(r_ld, r_lv, r_st, r_sp, r_c, r_ar, ps_div);
        chk($sformatf("rand[%0d]", i), m_q, m_tc, m_running);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/down_cnt_timer.md
Name: down_cnt_timer

Overview:
- Loadable, programmable down-counter/timer. It is the count-down complement to the team's free-running up-counter (CNT).
- Counts a programmed value down to zero on enabled cycles and flags terminal count. Optionally auto-reloads for periodic ticks.
- Used for pipeline stall timeouts, multi-cycle unit delays and periodic event generation.

Parameters:
M, 8, counter and load-value width in bits
PS_W, 4, prescaler width in bits (used only with DOWN_CNT_PRESCALE_EN)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
ce  input  1  count enable; one decrement opportunity per cycle when high
load  input  1  load load_val into counter and reload register
load_val  input  M  value to load
start  input  1  begin/resume counting
stop  input  1  pause counting
auto_reload  input  1  1 = reload at terminal count and keep running; 0 = one-shot
q  output  M  current count (registered)
tc  output  1  terminal-count pulse, one clk cycle wide (registered)
busy  output  1  high while in RUN (registered)
ps_div  input  PS_W  prescale divisor minus one (only with DOWN_CNT_PRESCALE_EN)

Behaviour:
- Reset (rst_n=0, async, no clock needed): q=0, reload register=0, tc=0, busy=0, state=IDLE, prescaler=0.
- States: IDLE, RUN, PAUSE, DONE.
- Per-edge priority: load > stop > start > count.
- load (any state): q<=load_val, reload<=load_val, state<=IDLE, busy<=0, tc<=0, prescaler<=0.
- start in IDLE or PAUSE:
  - q!=0: state<=RUN, busy<=1.
  - q==0: start is ignored and the state is unchanged.
- start in RUN or DONE: ignored.
- stop in RUN: state<=PAUSE, busy<=0, q held.
- stop in any other state: no effect.
- start and stop on the same edge: stop wins.
- RUN, ce=0: q held, tc<=0.
- RUN, ce=1, q>1: q<=q-1.
- RUN, ce=1, q==1 (final decrement):
  - tc<=1.
  - auto_reload=1 and reload!=0: q<=reload, stay RUN. Period is exactly reload enabled cycles.
  - Otherwise: q<=0, state<=DONE, busy<=0.
- tc asserts on the same edge q reaches 0 or reloads, and deasserts on the next edge unless another final decrement occurs. With reload=1 and ce held high, tc stays high continuously.
- DONE: q=0. Only load leaves DONE. ce, start and stop have no effect.
- Arithmetic is modulo 2^M. The counter never decrements from 0 (guarded by the q==1 terminal rule), so no wrap-around occurs.
- auto_reload is sampled at the final-decrement edge. Changing it mid-count affects only the next terminal event.
- Reset mid-operation aborts immediately. tc is never glitched high by reset.

Optional Feature:
DOWN_CNT_PRESCALE_EN
- Defined:
  - A PS_W-bit prescaler counts enabled ce cycles in RUN.
  - A decrement occurs only when prescaler==ps_div; the prescaler then clears, otherwise it increments.
  - Decrement rate is 1/(ps_div+1) of ce.
  - The prescaler holds in PAUSE and clears on load, reset and entry to DONE.
  - tc rules are unchanged, applied at the actual decrement.
- Undefined: no prescaler logic and no ps_div port. Every enabled ce in RUN decrements.

Test Plan:
1. Load 0x23, start, ce=1 for 3 clocks, then pull rst_n low between edges -> q=0, tc=0 and busy=0 immediately, without a clock edge.
2. Load 5, start, ce=1 continuous -> q runs 5,4,3,2,1,0 on successive edges. tc=1 only on the cycle q=0. busy falls on the same edge. Further ce/start leave q=0, tc=0.
3. auto_reload=1, load 3, start, ce=1 for 12 clocks -> q repeats 3,2,1,3,2,1,... and tc pulses every 3rd clock, 4 pulses total, busy stays 1.
4. Load 10, start, ce=1. After 2 decrements (q=8) assert stop and start together -> PAUSE with q=8 held for 5 clocks. Then start -> q=7 next edge.
5. Load 4, start, ce toggling 1/0 each clock -> tc on the 8th clock after start. Start with q=0 after reset -> busy stays 0, tc stays 0.
6. With DOWN_CNT_PRESCALE_EN, ps_div=2, load 2, start, ce=1 -> q=1 after 3 clocks, q=0 with tc after 6 clocks. load 0x80 asserted while RUN -> q=0x80, busy=0, IDLE.
